// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: word-update functions, checker state encoding, default polynomial.
package prbs_pkg;

    localparam int PRBS_PN    = 7;
    localparam int PRBS_TAP1  = 6;
    localparam int PRBS_TAP2  = 5;
    localparam int PRBS_WIDTH = 24;
    localparam int PRBS_MAX_W = 64;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    // One LFSR shift within a width-bit word; bits above width are forced to zero.
    function automatic logic [PRBS_MAX_W-1:0] prbs_step(input logic [PRBS_MAX_W-1:0] d,
                                                        input int width,
                                                        input int tap1,
                                                        input int tap2);
        logic [PRBS_MAX_W-1:0] mask;
        mask = (width >= PRBS_MAX_W) ? '1
                                     : ((PRBS_MAX_W'(1) << width) - PRBS_MAX_W'(1));
        return ((d << 1) | PRBS_MAX_W'(d[tap1] ^ d[tap2])) & mask;
    endfunction

    // Word-to-word update: width single-bit shifts.
    function automatic logic [PRBS_MAX_W-1:0] prbs_adv(input logic [PRBS_MAX_W-1:0] d,
                                                       input int width,
                                                       input int tap1,
                                                       input int tap2);
        logic [PRBS_MAX_W-1:0] r;
        r = d;
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < width) r = prbs_step(r, width, tap1, tap2);
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module prbs_popcount #(
    parameter int WIDTH = 24,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(d[i]);
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-synchronises to the incoming word stream, then counts
// bit and word errors with saturating counters.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int PN       = PRBS_PN,
    parameter int WIDTH    = PRBS_WIDTH,
    parameter int TAP1     = PRBS_TAP1,
    parameter int TAP2     = PRBS_TAP2,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_bits,
    output logic [CNT_W-1:0] err_words
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int MW    = $clog2(LOCK_CNT + 1);
    localparam int LW    = $clog2(LOSS_CNT + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    prbs_state_e      state, state_nxt;
    logic [WIDTH-1:0] pred, pred_nxt;
    logic             seed, seed_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [LW-1:0]    miss_cnt, miss_nxt;
    logic             pulse_nxt;
    logic             count_en;

    logic [WIDTH-1:0] adv_din, adv_pred;
    logic [PC_W-1:0]  nbits;
    logic [SUM_W-1:0] bits_sum;
    logic [CNT_W-1:0] bits_sat;

    assign adv_din  = WIDTH'(prbs_adv(PRBS_MAX_W'(din),  WIDTH, TAP1, TAP2));
    assign adv_pred = WIDTH'(prbs_adv(PRBS_MAX_W'(pred), WIDTH, TAP1, TAP2));

    prbs_popcount #(.WIDTH(WIDTH)) u_popcount (
        .d   (din ^ pred),
        .cnt (nbits)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEARCH;
            pred      <= '0;
            seed      <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            seed      <= seed_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        seed_nxt  = seed;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        pulse_nxt = 1'b0;
        count_en  = 1'b0;
        if (din_vld) begin
            case (state)
                SEARCH: begin
                    // All-zero low bits is the LFSR lock-up state and can never be a valid seed.
                    if (din[PN-1:0] == '0) begin
                        seed_nxt  = 1'b0;
                        match_nxt = '0;
                    end else begin
                        if (seed) match_nxt = (din == pred) ? match_cnt + MW'(1) : '0;
                        seed_nxt = 1'b1;
                        pred_nxt = adv_din;
                        if (match_nxt == MW'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                            miss_nxt  = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run the prediction so a single bad word is counted only once.
                    pred_nxt = adv_pred;
                    if (nbits != '0) begin
                        pulse_nxt = 1'b1;
                        count_en  = 1'b1;
                        miss_nxt  = miss_cnt + LW'(1);
                        if (miss_nxt == LW'(LOSS_CNT)) begin
                            state_nxt = SEARCH;
                            seed_nxt  = 1'b0;
                            match_nxt = '0;
                            miss_nxt  = '0;
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    assign bits_sum = SUM_W'(err_bits) + SUM_W'(nbits);
    assign bits_sat = (bits_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(bits_sum);

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            err_bits  <= '0;
            err_words <= '0;
        end else if (count_en) begin
            err_bits  <= bits_sat;
            err_words <= (&err_words) ? err_words : err_words + CNT_W'(1);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: two instances (32-bit and 4-bit counters) against a behavioural model.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] din;
    logic        din_vld;
    logic        clr_cnt;

    logic        locked,   err_pulse;
    logic [31:0] err_bits, err_words;
    logic        locked4,  err_pulse4;
    logic [3:0]  err_bits4, err_words4;

    prbs7_checker dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_bits(err_bits), .err_words(err_words)
    );

    prbs7_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_bits(err_bits4), .err_words(err_words4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    // behavioural model state
    bit          m_locked, m_seed, m_pulse;
    logic [23:0] m_pred;
    int          m_run, m_miss;
    longint      m_bits, m_words, m_bits4, m_words4;
    logic [23:0] gen;

    function automatic logic [23:0] adv(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < 24; i++) r = {r[22:0], r[6] ^ r[5]};
        return r;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic model_update();
        int nb;
        nb = 0;
        m_pulse = 0;
        if (!rst_n) begin
            m_locked = 0; m_seed = 0; m_pred = '0; m_run = 0; m_miss = 0;
            m_bits = 0; m_words = 0; m_bits4 = 0; m_words4 = 0;
            return;
        end
        if (din_vld) begin
            if (!m_locked) begin
                if (din[6:0] == 7'd0) begin
                    m_seed = 0; m_run = 0;
                end else begin
                    if (m_seed) m_run = (din == m_pred) ? m_run + 1 : 0;
                    m_seed = 1;
                    m_pred = adv(din);
                    if (m_run == 4) begin m_locked = 1; m_run = 0; m_miss = 0; end
                end
            end else begin
                nb = $countones(din ^ m_pred);
                m_pred = adv(m_pred);
                if (nb != 0) begin
                    m_pulse = 1;
                    m_miss++;
                    if (m_miss == 4) begin m_locked = 0; m_seed = 0; m_run = 0; m_miss = 0; end
                end else m_miss = 0;
            end
        end
        if (clr_cnt) begin
            m_bits = 0; m_words = 0; m_bits4 = 0; m_words4 = 0;
        end else if (nb != 0) begin
            m_bits   = sat(m_bits + nb, 64'hFFFF_FFFF);
            m_words  = sat(m_words + 1, 64'hFFFF_FFFF);
            m_bits4  = sat(m_bits4 + nb, 15);
            m_words4 = sat(m_words4 + 1, 15);
        end
    endtask

    task automatic drive(input logic [23:0] d, input logic v, input logic c);
        @(negedge clk);
        din = d; din_vld = v; clr_cnt = c;
        @(posedge clk);
        model_update();
    endtask

    task automatic clean_word();
        drive(gen, 1'b1, 1'b0);
        gen = adv(gen);
    endtask

    task automatic bad_word(input logic c);
        drive(~gen, 1'b1, c);
        gen = adv(gen);
    endtask

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("locked",     locked,     64'(m_locked));
            chk("err_pulse",  err_pulse,  64'(m_pulse));
            chk("err_bits",   err_bits,   m_bits);
            chk("err_words",  err_words,  m_words);
            chk("locked4",    locked4,    64'(m_locked));
            chk("err_pulse4", err_pulse4, 64'(m_pulse));
            chk("err_bits4",  err_bits4,  m_bits4);
            chk("err_words4", err_words4, m_words4);
        end
    end

    initial begin
        rst_n = 1'b0; din = '0; din_vld = 1'b0; clr_cnt = 1'b0;
        gen = 24'h1;
        drive('0, 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        started = 1;
        #1;
        chk("reset_locked", locked, 0);
        chk("reset_bits",   err_bits, 0);
        chk("reset_pulse",  err_pulse, 0);
        rst_n = 1'b1;

        // all-zero words must never seed or lock
        for (int i = 0; i < 20; i++) drive('0, 1'b1, 1'b0);
        #1 chk("zeros_nolock", locked, 0);
        chk("zeros_bits", err_bits, 0);

        // clean stream: lock visible right after the 5th valid word
        for (int i = 0; i < 4; i++) clean_word();
        #1 chk("lock_w4", locked, 0);
        clean_word();
        #1 chk("lock_w5", locked, 1);
        for (int i = 0; i < 1000; i++) clean_word();
        #1 chk("clean_bits", err_bits, 0);
        chk("clean_words", err_words, 0);

        // single-bit error
        drive(gen ^ 24'h1, 1'b1, 1'b0);
        gen = adv(gen);
        #1 chk("flip_pulse", err_pulse, 1);
        chk("flip_bits", err_bits, 1);
        chk("flip_words", err_words, 1);
        clean_word();
        #1 chk("flip_pulse_gone", err_pulse, 0);
        chk("flip_locked", locked, 1);

        // clear, then four fully inverted words drop lock
        drive(gen, 1'b1, 1'b1);
        gen = adv(gen);
        for (int i = 0; i < 3; i++) bad_word(1'b0);
        #1 chk("inv3_locked", locked, 1);
        bad_word(1'b0);
        #1 chk("inv4_locked", locked, 0);
        chk("inv_bits", err_bits, 96);
        chk("inv_words", err_words, 4);
        chk("inv_bits4_sat", err_bits4, 15);
        for (int i = 0; i < 4; i++) clean_word();
        #1 chk("relock_w4", locked, 0);
        clean_word();
        #1 chk("relock_w5", locked, 1);

        // gaps: garbage on din while invalid must be ignored
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) clean_word();
            else drive(24'($urandom), 1'b0, 1'b0);
        end
        #1 chk("gap_bits", err_bits, 96);
        chk("gap_locked", locked, 1);

        // clear beats a same-cycle error, pulse still fires
        bad_word(1'b1);
        #1 chk("clr_pulse", err_pulse, 1);
        chk("clr_bits", err_bits, 0);
        chk("clr_words", err_words, 0);

        // saturation of the 4-bit counter, then mid-stream reset
        bad_word(1'b0);
        bad_word(1'b0);
        #1 chk("sat_bits4", err_bits4, 15);
        chk("sat_bits32", err_bits, 48);
        chk("sat_locked", locked, 1);
        rst_n = 1'b0;
        clean_word();
        #1 chk("rst_locked", locked, 0);
        chk("rst_bits", err_bits, 0);
        chk("rst_words4", err_words4, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) clean_word();
        #1 chk("post_rst_lock", locked, 1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
